// File: rtl/dmem_pkg.sv
// Shared access-size codes, responder state encoding and the access legality rule.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned half/word, reserved size codes, or an unsigned-size store.
    function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lsb);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lsb[0];
            F3_W:    bad = (lsb != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | lsb[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus: request/store operands in, load result and status out.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (output req, we, funct3, addr, wdata,
                    input  rdata, ready, busy, err);
    modport slave  (input  req, we, funct3, addr, wdata,
                    output rdata, ready, busy, err);
endinterface

// File: rtl/dmem_responder_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*addr_i +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    result_o = word_i;
            F3_BU:   result_o = {24'b0, byte_sel};
            F3_HU:   result_o = {16'b0, half_sel};
            default: result_o = '0;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one access from IDLE, waits LATENCY
// cycles, performs the read/write on the edge into RESP and pulses ready for one cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem_q [DEPTH];

    logic            acc_go;
    logic            a_we;
    logic [2:0]      a_f3;
    logic [AW+1:0]   a_addr;
    logic [31:0]     a_wdata;
    logic [AW-1:0]   a_idx;
    logic            a_bad;
    logic [3:0]      a_be;
    logic [31:0]     a_wword, a_old, a_ld;
    logic            unused_addr_hi;

    // Address bits above the array wrap around.
    assign unused_addr_hi = ^bus.addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_go  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.req) begin
                if (LATENCY == 0) begin
                    state_d = ST_RESP;
                    acc_go  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(LATENCY);
                end
            end
            ST_WAIT: if (cnt_q == 4'd1) begin
                state_d = ST_RESP;
                cnt_d   = 4'd0;
                acc_go  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY=0 the access completes on the accepting edge, so use the live bus.
    always_comb begin
        if (state_q == ST_IDLE) begin
            a_we    = bus.we;
            a_f3    = bus.funct3;
            a_addr  = bus.addr[AW+1:0];
            a_wdata = bus.wdata;
        end else begin
            a_we    = we_q;
            a_f3    = f3_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
    end

    assign a_idx = a_addr[AW+1:2];
    assign a_bad = access_bad(a_we, a_f3, a_addr[1:0]);
    assign a_old = mem_q[a_idx];

    always_comb begin
        a_be    = 4'b1111;
        a_wword = a_wdata;
        case (a_f3[1:0])
            2'b00: begin
                a_be    = 4'b0001 << a_addr[1:0];
                a_wword = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                a_be    = a_addr[1] ? 4'b1100 : 4'b0011;
                a_wword = {2{a_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    load_extend u_ext (
        .word_i   (a_old),
        .addr_i   (a_addr[1:0]),
        .funct3_i (a_f3),
        .result_o (a_ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && bus.req) begin
                we_q    <= bus.we;
                f3_q    <= bus.funct3;
                addr_q  <= bus.addr[AW+1:0];
                wdata_q <= bus.wdata;
            end
            // rdata holds while an access is in flight; a completed store or fault leaves 0.
            if (acc_go) begin
                err_q   <= a_bad;
                rdata_q <= (a_we || a_bad) ? '0 : a_ld;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (acc_go && a_we && !a_bad) begin
            for (int b = 0; b < 4; b++)
                if (a_be[b]) mem_q[a_idx][8*b +: 8] <= a_wword[8*b +: 8];
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = (state_q == ST_RESP);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.err   = err_q & (state_q == ST_RESP);

endmodule
